wb_queue: RTL and testbench
===========================

Name: wb_queue

Overview:
- Writeback buffer directly downstream of the load/store stage.
- Each cycle it accepts up to two register writebacks, one on lane A and one on lane B.
- It queues them in order and drains one per cycle into the single write port of the register file, using a valid/ready handshake.
- It gives back-pressure (stall) to the issue logic and a pending-write lookup for hazard checks.

Parameters:
- DEPTH, 8, number of queue entries; must be a power of two and at least 4.
- ADDR_W, 5, register address width.
- DATA_W, 16, register data width.

Ports:
- clock_i  in  1  single system clock; all state changes on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- wbEnableA_i  in  1  lane A writeback valid.
- wbAddressA_i  in  ADDR_W  lane A destination register.
- wbDataA_i  in  DATA_W  lane A data.
- wbEnableB_i  in  1  lane B writeback valid.
- wbAddressB_i  in  ADDR_W  lane B destination register.
- wbDataB_i  in  DATA_W  lane B data.
- rfWrReady_i  in  1  register file accepts a write this cycle.
- rfWrEnable_o  out  1  head entry valid (queue not empty).
- rfWrAddress_o  out  ADDR_W  head entry address.
- rfWrData_o  out  DATA_W  head entry data.
- stall_o  out  1  fewer than 2 free entries; upstream must hold issue.
- count_o  out  log2(DEPTH)+1  number of occupied entries.
- overflow_o  out  1  sticky error: a push was dropped.
- queryAddress_i  in  ADDR_W  register to check for a pending write.
- queryHit_o  out  1  some occupied entry targets queryAddress_i.

Behaviour:
- Reset, asynchronous, while reset_n_i=0:
  - rd/wr pointers, count_o and overflow_o go to 0.
  - rfWrEnable_o goes to 0; rfWrAddress_o and rfWrData_o go to 0.
  - stall_o goes to 0; queryHit_o goes to 0.
  - Any write in flight is discarded with no partial state.
- Storage: circular buffer of {address, data}. Pointers wrap modulo DEPTH. Full/empty is decided from count, not pointer equality.
- Pop:
  - pop = rfWrEnable_o & rfWrReady_i.
  - On pop the read pointer advances at the clock edge and the next entry appears on the outputs in the same cycle.
- Push order within a cycle: lane A is written before lane B. pushes = wbEnableA_i + wbEnableB_i.
- Same-address pair: if lane A and lane B target the same address in one cycle, both are enqueued, A then B, so B's data lands last in the register file. Nothing is merged or dropped.
- Capacity check: space = DEPTH - count + pop, so a simultaneous pop frees a slot in the same cycle.
  - If pushes <= space, all valid lanes are accepted.
  - If only one slot is free, lane A is accepted and lane B is dropped.
  - If no slot is free, both lanes are dropped.
  - Any dropped valid lane sets overflow_o, which stays set until reset.
- count update: count_next = count + accepted - pop, applied at the edge.
- Latency:
  - Push into an empty queue at edge N drives rfWrEnable_o=1 with that entry after edge N.
  - There is no combinational path from the wb*_i inputs to the rf outputs.
- Head outputs:
  - rfWrEnable_o = (count != 0).
  - rfWrAddress_o and rfWrData_o are the entry at the read pointer; they hold while rfWrReady_i=0.
  - When empty, rfWrAddress_o and rfWrData_o are 0.
- stall_o: combinational, = (DEPTH - count) < 2. Computed from registered count only; rfWrReady_i does not enter it.
- queryHit_o: combinational OR over occupied entries of (address == queryAddress_i). Entries outside the occupied range are ignored, including when the pointers have wrapped.
- Full with simultaneous push and pop:
  - One push with one pop: accepted, count unchanged.
  - Two pushes with one pop: A accepted, B dropped, overflow set.

Decomposition:
- Shared package wb_pkg holds:
  - ADDR_W, DATA_W and the wb_entry_t struct {addr, data}.
  - The WB_DEPTH default.
  - The REG_ZERO constant.
- The issue stage and the register file import wb_pkg as well.
- One sub-module is natural: wb_queue_mem, a DEPTH x entry storage array with two write ports (A, B) and one read port. wb_queue itself keeps the pointers, count, capacity logic and query compare.

Test Plan:
- Reset and idle: reset_n_i=0 mid-stream with count=3 -> count_o=0, rfWrEnable_o=0, overflow_o=0 immediately, before any clock edge.
- Dual push into empty queue: A=(r3,0x1111), B=(r7,0x2222), rfWrReady_i=1 -> next cycles present r3/0x1111 then r7/0x2222, then rfWrEnable_o=0.
- Same-address ordering: A=(r5,0xAAAA), B=(r5,0xBBBB) -> writes r5=0xAAAA then r5=0xBBBB; the register-file model ends with 0xBBBB.
- Back-pressure:
  - rfWrReady_i=0 with dual pushes until count=7 -> stall_o=1 at count>=7.
  - At count=7 a dual push -> A accepted, count=8, overflow_o=1 and sticky.
- Full with pop: count=8, rfWrReady_i=1, single push A=(r2,0x0042) -> count stays 8, overflow unchanged, r2 entry at tail.
- Wrap and query:
  - Push and drain 11 entries with DEPTH=8 so the pointers wrap.
  - queryAddress_i=r9 while r9 is pending -> queryHit_o=1.
  - After r9 pops -> queryHit_o=0; stale slot contents are not reported.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared writeback types and defaults, used by the issue stage, the register file and
// the writeback queue.
package wb_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned WB_DEPTH = 8;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_queue_mem.sv
// Writeback queue storage: DEPTH entries, two write ports (A, B) and one read port.
// The full array is also exported so the pending-write lookup can scan it.
module wb_queue_mem #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned ENTRY_W = 21
) (
  input  logic                              clk_i,
  input  logic                              we_a_i,
  input  logic [$clog2(DEPTH)-1:0]          idx_a_i,
  input  logic [ENTRY_W-1:0]                data_a_i,
  input  logic                              we_b_i,
  input  logic [$clog2(DEPTH)-1:0]          idx_b_i,
  input  logic [ENTRY_W-1:0]                data_b_i,
  input  logic [$clog2(DEPTH)-1:0]          rd_idx_i,
  output logic [ENTRY_W-1:0]                rd_data_o,
  output logic [DEPTH-1:0][ENTRY_W-1:0]     entries_o
);

  logic [DEPTH-1:0][ENTRY_W-1:0] mem_q;

  // Occupancy is tracked by the owner, so the storage itself needs no reset.
  always_ff @(posedge clk_i) begin
    if (we_a_i) mem_q[idx_a_i] <= data_a_i;
    if (we_b_i) mem_q[idx_b_i] <= data_b_i;
  end

  assign rd_data_o = mem_q[rd_idx_i];
  assign entries_o = mem_q;

endmodule

// File: rtl/wb_queue.sv
// Dual-lane writeback queue feeding the single register-file write port, with
// back-pressure, sticky overflow and a pending-write lookup for hazard checks.
module wb_queue
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH  = WB_DEPTH,
  parameter int unsigned ADDR_W = wb_pkg::ADDR_W,
  parameter int unsigned DATA_W = wb_pkg::DATA_W
) (
  input  logic                       clock_i,
  input  logic                       reset_n_i,
  input  logic                       wbEnableA_i,
  input  logic [ADDR_W-1:0]          wbAddressA_i,
  input  logic [DATA_W-1:0]          wbDataA_i,
  input  logic                       wbEnableB_i,
  input  logic [ADDR_W-1:0]          wbAddressB_i,
  input  logic [DATA_W-1:0]          wbDataB_i,
  input  logic                       rfWrReady_i,
  output logic                       rfWrEnable_o,
  output logic [ADDR_W-1:0]          rfWrAddress_o,
  output logic [DATA_W-1:0]          rfWrData_o,
  output logic                       stall_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  input  logic [ADDR_W-1:0]          queryAddress_i,
  output logic                       queryHit_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = ADDR_W + DATA_W;
  localparam logic [CntW-1:0] DepthC    = CntW'(DEPTH);
  localparam logic [CntW-1:0] StallLvlC = CntW'(DEPTH - 1);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, idx_b, q_off;
  logic [CntW-1:0] cnt_q, cnt_d, space, n_acc;
  logic            ovf_q, ovf_d;
  logic            empty, pop, acc_a, acc_b;
  logic [EntW-1:0] head;
  logic [DEPTH-1:0][EntW-1:0] entries;

  assign empty = (cnt_q == '0);
  assign pop   = ~empty & rfWrReady_i;

  always_comb begin
    space = DepthC - cnt_q + CntW'(pop);
    acc_a = wbEnableA_i & (space != '0);
    // B needs a slot of its own beyond the one A may have taken.
    acc_b = wbEnableB_i & (space > CntW'(acc_a));
    idx_b = wr_ptr_q + PtrW'(acc_a);
    n_acc = CntW'(acc_a) + CntW'(acc_b);

    cnt_d    = cnt_q + n_acc - CntW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(n_acc);
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    ovf_d    = ovf_q | (wbEnableA_i & ~acc_a) | (wbEnableB_i & ~acc_b);
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  wb_queue_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (EntW)
  ) u_mem (
    .clk_i     (clock_i),
    .we_a_i    (acc_a),
    .idx_a_i   (wr_ptr_q),
    .data_a_i  ({wbAddressA_i, wbDataA_i}),
    .we_b_i    (acc_b),
    .idx_b_i   (idx_b),
    .data_b_i  ({wbAddressB_i, wbDataB_i}),
    .rd_idx_i  (rd_ptr_q),
    .rd_data_o (head),
    .entries_o (entries)
  );

  assign rfWrEnable_o  = ~empty;
  assign rfWrAddress_o = empty ? '0 : head[EntW-1 -: ADDR_W];
  assign rfWrData_o    = empty ? '0 : head[DATA_W-1:0];
  assign stall_o       = (cnt_q >= StallLvlC);
  assign count_o       = cnt_q;
  assign overflow_o    = ovf_q;

  // A slot is occupied when its distance from the read pointer is below the count.
  always_comb begin
    queryHit_o = 1'b0;
    q_off      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_off = PtrW'(i) - rd_ptr_q;
      if (({1'b0, q_off} < cnt_q) && (entries[i][EntW-1 -: ADDR_W] == queryAddress_i)) begin
        queryHit_o = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: expected writebacks go into a scoreboard queue and a
// monitor compares every register-file write as it is presented.
module tb_wb_queue;
  import wb_pkg::*;

  logic        clock_i = 1'b0;
  logic        reset_n_i;
  logic        wbEnableA_i, wbEnableB_i, rfWrReady_i;
  logic [4:0]  wbAddressA_i, wbAddressB_i, queryAddress_i;
  logic [15:0] wbDataA_i, wbDataB_i;
  logic        rfWrEnable_o, stall_o, overflow_o, queryHit_o;
  logic [4:0]  rfWrAddress_o;
  logic [15:0] rfWrData_o;
  logic [3:0]  count_o;

  int unsigned errors = 0;
  int unsigned checks = 0;
  wb_entry_t   exp_q[$];
  logic [15:0] rf_model [32];

  wb_queue dut (
    .clock_i        (clock_i),
    .reset_n_i      (reset_n_i),
    .wbEnableA_i    (wbEnableA_i),
    .wbAddressA_i   (wbAddressA_i),
    .wbDataA_i      (wbDataA_i),
    .wbEnableB_i    (wbEnableB_i),
    .wbAddressB_i   (wbAddressB_i),
    .wbDataB_i      (wbDataB_i),
    .rfWrReady_i    (rfWrReady_i),
    .rfWrEnable_o   (rfWrEnable_o),
    .rfWrAddress_o  (rfWrAddress_o),
    .rfWrData_o     (rfWrData_o),
    .stall_o        (stall_o),
    .count_o        (count_o),
    .overflow_o     (overflow_o),
    .queryAddress_i (queryAddress_i),
    .queryHit_o     (queryHit_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit model_hit(input logic [4:0] a);
    foreach (exp_q[i]) if (exp_q[i].addr == a) return 1'b1;
    return 1'b0;
  endfunction

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  // Drive one cycle of writebacks; xa/xb say which lanes must be accepted.
  task automatic push_cyc(input logic ea, input logic [4:0] aa, input logic [15:0] da,
                          input logic eb, input logic [4:0] ab, input logic [15:0] db,
                          input bit xa, input bit xb);
    wb_entry_t e;
    wbEnableA_i = ea; wbAddressA_i = aa; wbDataA_i = da;
    wbEnableB_i = eb; wbAddressB_i = ab; wbDataB_i = db;
    cyc();
    if (xa) begin e.addr = aa; e.data = da; exp_q.push_back(e); end
    if (xb) begin e.addr = ab; e.data = db; exp_q.push_back(e); end
    wbEnableA_i = 1'b0;
    wbEnableB_i = 1'b0;
  endtask

  always @(negedge clock_i) begin
    wb_entry_t e;
    if (reset_n_i) begin
      chk("rf_enable", 32'(rfWrEnable_o), 32'(exp_q.size() != 0));
      if (rfWrEnable_o && rfWrReady_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rf_addr", 32'(rfWrAddress_o), 32'(e.addr));
          chk("rf_data", 32'(rfWrData_o), 32'(e.data));
          rf_model[rfWrAddress_o] = rfWrData_o;
        end
      end
    end
  end

  initial begin
    reset_n_i = 1'b0; rfWrReady_i = 1'b0; queryAddress_i = '0;
    wbEnableA_i = 1'b0; wbAddressA_i = '0; wbDataA_i = '0;
    wbEnableB_i = 1'b0; wbAddressB_i = '0; wbDataB_i = '0;
    foreach (rf_model[i]) rf_model[i] = '0;
    repeat (2) cyc();
    reset_n_i = 1'b1;

    // Asynchronous reset mid-stream with three entries queued.
    push_cyc(1, 5'd1, 16'h0011, 1, 5'd2, 16'h0022, 1, 1);
    push_cyc(1, 5'd4, 16'h0044, 0, 5'd0, 16'h0000, 1, 0);
    chk("count_pre_reset", 32'(count_o), 3);
    queryAddress_i = 5'd1;
    #1 chk("hit_pre_reset", 32'(queryHit_o), 1);
    #1 reset_n_i = 1'b0;
    exp_q.delete();
    #1;
    chk("reset_count", 32'(count_o), 0);
    chk("reset_enable", 32'(rfWrEnable_o), 0);
    chk("reset_overflow", 32'(overflow_o), 0);
    chk("reset_addr", 32'(rfWrAddress_o), 32'(REG_ZERO));
    chk("reset_data", 32'(rfWrData_o), 0);
    chk("reset_stall", 32'(stall_o), 0);
    chk("reset_hit", 32'(queryHit_o), 0);
    cyc();
    reset_n_i = 1'b1;

    // Dual push into an empty queue, drained in order.
    rfWrReady_i = 1'b1;
    push_cyc(1, 5'd3, 16'h1111, 1, 5'd7, 16'h2222, 1, 1);
    chk("dual_count2", 32'(count_o), 2);
    cyc();
    chk("dual_count1", 32'(count_o), 1);
    cyc();
    chk("dual_count0", 32'(count_o), 0);
    chk("dual_empty", 32'(rfWrEnable_o), 0);

    // Same destination on both lanes: B's data must land last.
    push_cyc(1, 5'd5, 16'hAAAA, 1, 5'd5, 16'hBBBB, 1, 1);
    repeat (2) cyc();
    chk("same_addr_final", 32'(rf_model[5]), 32'hBBBB);

    // Back-pressure: fill with the register file stalled.
    rfWrReady_i = 1'b0;
    push_cyc(1, 5'd10, 16'h0100, 1, 5'd11, 16'h0101, 1, 1);
    chk("bp_count2", 32'(count_o), 2);
    push_cyc(1, 5'd12, 16'h0102, 1, 5'd13, 16'h0103, 1, 1);
    push_cyc(1, 5'd14, 16'h0104, 1, 5'd15, 16'h0105, 1, 1);
    chk("bp_count6", 32'(count_o), 6);
    chk("bp_stall6", 32'(stall_o), 0);
    push_cyc(1, 5'd16, 16'h0106, 0, 5'd0, 16'h0000, 1, 0);
    chk("bp_count7", 32'(count_o), 7);
    chk("bp_stall7", 32'(stall_o), 1);
    chk("bp_ovf7", 32'(overflow_o), 0);
    push_cyc(1, 5'd17, 16'h0107, 1, 5'd18, 16'h0108, 1, 0);
    chk("bp_count8", 32'(count_o), 8);
    chk("bp_ovf8", 32'(overflow_o), 1);
    cyc();
    chk("bp_ovf_sticky", 32'(overflow_o), 1);

    // Full with a simultaneous pop: the single push fits.
    rfWrReady_i = 1'b1;
    push_cyc(1, 5'd2, 16'h0042, 0, 5'd0, 16'h0000, 1, 0);
    chk("fullpop_count", 32'(count_o), 8);
    chk("fullpop_ovf", 32'(overflow_o), 1);
    chk("fullpop_stall", 32'(stall_o), 1);
    repeat (8) cyc();
    chk("drain_count", 32'(count_o), 0);
    chk("drain_sb_empty", 32'(exp_q.size()), 0);

    // Wrap the pointers while tracking a pending write to r9.
    queryAddress_i = 5'd9;
    for (int c = 0; c < 6; c++) begin
      logic [4:0] a0, a1;
      a0 = 5'(20 + 2 * c);
      a1 = (c == 1) ? 5'd9 : 5'(21 + 2 * c);
      if (c < 5) push_cyc(1, a0, 16'(16'h0300 + 2 * c), 1, a1, 16'(16'h0301 + 2 * c), 1, 1);
      else       push_cyc(1, a0, 16'(16'h0300 + 2 * c), 0, 5'd0, 16'h0000, 1, 0);
      if (c == 1) chk("hit_r9_pending", 32'(queryHit_o), 1);
      else        chk("wrap_hit", 32'(queryHit_o), 32'(model_hit(5'd9)));
    end
    for (int c = 0; c < 7; c++) begin
      cyc();
      chk("drain_hit", 32'(queryHit_o), 32'(model_hit(5'd9)));
    end
    chk("wrap_count", 32'(count_o), 0);
    chk("hit_after_pop", 32'(queryHit_o), 0);
    chk("wrap_sb_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
